// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and requester indices.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: sched_state_t, REQ_A/REQ_B, req_onehot() helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    GAP        = 3'd4,
    HOLD       = 3'd5
  } sched_state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  // One-hot grant vector for a requester index.
  function automatic logic [1:0] req_onehot(input logic idx);
    logic [1:0] v;
    v      = 2'b00;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Bundle between two byte requesters, the UART transmitter load port and the scheduler.
// Latency: none (wiring only).
// Backpressure: valid/ready per requester; transmitter paced by tx_busy.
// master = scheduler side, slave = requesters + transmitter side.
interface uart_tx_sched_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_last;
  logic       b_ready;
  logic       tx_load;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic [1:0] grant;
  logic       sched_busy;
  logic       start_err;

  modport master (
    input  a_valid, a_data, a_last,
    output a_ready,
    input  b_valid, b_data, b_last,
    output b_ready,
    output tx_load, tx_byte,
    input  tx_busy,
    output grant, sched_busy, start_err
  );

  modport slave (
    output a_valid, a_data, a_last,
    input  a_ready,
    output b_valid, b_data, b_last,
    input  b_ready,
    input  tx_load, tx_byte,
    output tx_busy,
    input  grant, sched_busy, start_err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not own the last frame wins.
// Latency: grant is combinational from i_req; owner history updates one edge after i_upd.
// Backpressure: none; caller decides when a grant is consumed.
// Ports: clk, rst, i_req[1:0], i_upd (frame completed), i_upd_idx (its owner), o_gnt[1:0] one-hot.
module rr_arb2
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_idx,
  output logic [1:0] o_gnt
);

  // Index of the requester that owned the most recently completed frame.
  logic r_last_owner;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= 1'(REQ_A);
    end else if (i_upd) begin
      r_last_owner <= i_upd_idx;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = req_onehot(~r_last_owner);
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Frame-level scheduler sharing one byte-wide UART transmitter between requesters A and B.
// Latency: byte accepted in cycle N is loaded (tx_load) in cycle N+1.
// Backpressure: ready only in IDLE/HOLD; grant locked per frame; loads paced by tx_busy + GAP_CYC.
// Ports: clk, rst (sync, active-high), bus (master modport: requesters, tx load port, status).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int GAP_CYC  = 0,
  parameter int START_TO = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.master bus
);

  localparam int TO_W  = (START_TO < 1) ? 1 : $clog2(START_TO + 1);
  localparam int GAP_W = (GAP_CYC < 1)  ? 1 : $clog2(GAP_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(START_TO);

  sched_state_t     r_state;
  logic [7:0]       r_byte;
  logic             r_last;
  logic             r_tx_load;
  logic [1:0]       r_grant;
  logic             r_sched_busy;
  logic             r_start_err;
  logic [TO_W-1:0]  r_to_cnt;
  logic [GAP_W-1:0] r_gap_cnt;

  logic [1:0] w_req;
  logic [1:0] w_arb_gnt;
  logic       w_acc_a;
  logic       w_acc_b;
  logic       w_accept;
  logic       w_to_hit;
  logic       w_gap_hit;
  logic       w_byte_done;
  logic       w_finish;
  logic       w_frame_end;

  assign w_req[REQ_A] = bus.a_valid;
  assign w_req[REQ_B] = bus.b_valid;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_req),
    .i_upd     (w_frame_end),
    .i_upd_idx (r_grant[REQ_B]),
    .o_gnt     (w_arb_gnt)
  );

  // In HOLD only the frame owner can be accepted; reset suppresses any ready.
  assign w_acc_a = !rst && (((r_state == IDLE) && w_arb_gnt[REQ_A]) ||
                            ((r_state == HOLD) && r_grant[REQ_A] && bus.a_valid));
  assign w_acc_b = !rst && (((r_state == IDLE) && w_arb_gnt[REQ_B]) ||
                            ((r_state == HOLD) && r_grant[REQ_B] && bus.b_valid));
  assign w_accept = w_acc_a || w_acc_b;

  // Counter value seen in this cycle plus one: the timeout fires on the START_TO-th
  // WAIT_START cycle, so start_err shows START_TO+1 cycles after the load.
  assign w_to_hit  = (int'(r_to_cnt) + 1) >= START_TO;
  assign w_gap_hit = (int'(r_gap_cnt) + 1) >= GAP_CYC;

  // A byte counts as done on busy fall, or on a start timeout (the byte is dropped).
  assign w_byte_done = !bus.tx_busy &&
                       (((r_state == WAIT_START) && w_to_hit) || (r_state == WAIT_DONE));

  // With no gap the byte-done transition goes straight to HOLD/IDLE.
  assign w_finish    = ((GAP_CYC == 0) && w_byte_done) || ((r_state == GAP) && w_gap_hit);
  assign w_frame_end = w_finish && r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_byte       <= 8'h00;
      r_last       <= 1'b0;
      r_tx_load    <= 1'b0;
      r_grant      <= 2'b00;
      r_sched_busy <= 1'b0;
      r_start_err  <= 1'b0;
      r_to_cnt     <= '0;
      r_gap_cnt    <= '0;
    end else begin
      r_tx_load   <= 1'b0;
      r_start_err <= 1'b0;

      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            r_byte       <= w_acc_b ? bus.b_data : bus.a_data;
            r_last       <= w_acc_b ? bus.b_last : bus.a_last;
            if (r_state == IDLE) begin
              r_grant <= req_onehot(w_acc_b);
            end
            r_tx_load    <= 1'b1;
            r_sched_busy <= 1'b1;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          r_to_cnt <= '0;
          r_state  <= WAIT_START;
        end
        WAIT_START: begin
          if (bus.tx_busy) begin
            r_state <= WAIT_DONE;
          end else if (w_to_hit) begin
            r_start_err <= 1'b1;
          end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          // exit handled by the byte-done logic below
        end
        GAP: begin
          if (!w_gap_hit) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Byte completion overrides the per-state next state above.
      if (w_finish) begin
        if (r_last) begin
          r_grant      <= 2'b00;
          r_sched_busy <= 1'b0;
          r_state      <= IDLE;
        end else begin
          r_state <= HOLD;
        end
      end else if (w_byte_done) begin
        r_gap_cnt <= '0;
        r_state   <= GAP;
      end
    end
  end

  assign bus.a_ready    = w_acc_a;
  assign bus.b_ready    = w_acc_b;
  assign bus.tx_load    = r_tx_load;
  assign bus.tx_byte    = r_byte;
  assign bus.grant      = r_grant;
  assign bus.sched_busy = r_sched_busy;
  assign bus.start_err  = r_start_err;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Frame-level scheduler that shares the single byte-wide UART transmitter between two byte-stream requesters. It sits between the command/response logic and the transmitter's load interface (`comnd_en`/`comnd_data` in, `bps_start` as busy out). It arbitrates round-robin per frame, locks the grant until the frame's last byte has gone out, and paces the loads against the transmitter busy signal. Optionally it inserts an inter-byte idle gap and flags transmitters that never start.

## Interface
- `GAP_CYC`, default 0: idle clk cycles inserted after each byte completes, before the next load.
- `START_TO`, default 16: clk cycles allowed between `tx_load` and `tx_busy` rising before a start-timeout error is declared.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `a_valid`  in  1  requester A has a byte.
- `a_data`  in  8  requester A byte.
- `a_last`  in  1  byte is the last of A's frame.
- `a_ready`  out  1  A's byte is accepted this cycle.
- `b_valid`, `b_data`, `b_last`, `b_ready`: same as the A set, for requester B.
- `tx_load`  out  1  one-cycle load strobe to the transmitter (`comnd_en`).
- `tx_byte`  out  8  byte to the transmitter (`comnd_data`); held stable from load until the next load.
- `tx_busy`  in  1  transmitter busy (`bps_start`); high from shortly after load until the stop bit finishes.
- `grant`  out  2  one-hot owner of the current frame; 00 when no frame is in progress.
- `sched_busy`  out  1  high in every state except IDLE.
- `start_err`  out  1  one-cycle pulse on a start timeout.

## Operation
- States:
  - IDLE: no frame lock.
  - LOAD: pulse `tx_load`.
  - WAIT_START: wait for `tx_busy` to rise.
  - WAIT_DONE: wait for `tx_busy` to fall.
  - GAP: count `GAP_CYC` idle cycles.
  - HOLD: frame locked, waiting for the owner's next byte.
- IDLE, arbitration:
  - If exactly one requester has `valid`, it wins.
  - If both have `valid`, the winner is the one that did not own the previous frame. After reset, A is treated as having owned the last frame, so B wins the first tie.
  - The winner's `ready` is high combinationally in the same cycle. The byte and its last flag are latched, `grant` is set, and the next state is LOAD.
- LOAD: `tx_load` is high for exactly one cycle and `tx_byte` shows the latched byte. Next state is WAIT_START; the timeout counter is cleared.
- WAIT_START:
  - On `tx_busy` high, go to WAIT_DONE.
  - When the counter reaches `START_TO`, pulse `start_err`, drop the byte, and treat it as completed (go to GAP). The frame continues.
- WAIT_DONE: on `tx_busy` low, go to GAP. There is no timeout in this state.
- GAP: hold for `GAP_CYC` cycles (0 means zero cycles, i.e. pass straight through combinationally within the same transition). Then:
  - if the latched last flag is set, clear `grant` and go to IDLE;
  - otherwise go to HOLD.
- HOLD:
  - Only the owner's `ready` may assert: high combinationally when the owner's `valid` is high, in which case latch the byte and go to LOAD.
  - The non-owner is ignored; its `valid` may stay high indefinitely.
- `ready` is never asserted outside IDLE and HOLD. A requester whose `valid` drops before acceptance is simply not served.
- A `last` on a single-byte frame accepted in IDLE completes the frame after one byte.

## Timing
- Reset values (synchronous, applied on the clk edge while `rst` is high; mid-frame reset aborts immediately):
  - state IDLE;
  - `tx_load` 0, `tx_byte` 00, `grant` 00, `sched_busy` 0, `start_err` 0, `a_ready`/`b_ready` 0;
  - round-robin pointer set to "A last".
- Latency: accept in cycle N, then `tx_load` in cycle N+1.
- Minimum spacing between consecutive loads: load, plus 1 WAIT_START cycle, plus the transmitter busy time, plus 1 WAIT_DONE exit cycle, plus `GAP_CYC`, plus 1 HOLD/IDLE accept cycle.
- `tx_busy` already high on entry to WAIT_START counts immediately: the transition happens on the next edge.
- A `tx_busy` glitch (high then low) inside WAIT_START is treated as a completed byte: the rise moves to WAIT_DONE, the fall moves to GAP.
- Timeout counter width: `$clog2(START_TO+1)`. It saturates and never wraps.
- Gap counter width: `$clog2(GAP_CYC+1)`, minimum 1 bit.
- `rst` asserted together with `valid` in the same cycle: reset wins and no `ready` is issued.

## Structure
- Shared package `uart_pkg`:
  - state enum `sched_state_t`;
  - requester index constants `REQ_A = 0`, `REQ_B = 1`.
- One natural sub-module: `rr_arb2`, a two-way round-robin arbiter with a last-owner register that updates only on frame completion.
- Everything else (FSM, counters, byte latch) lives in the top module.

## Test plan
- A sends a 3-byte frame 0x55, 0xAA, 0x0D; `tx_busy` model is 10 cycles busy, starting 1 cycle after load. Required: `tx_byte` sequence 55/AA/0D, three `tx_load` pulses, `grant`=01 throughout, back to IDLE.
- A and B are both valid from reset with 1-byte frames 0x11 and 0x22. Required: B is served first (0x22), then A (0x11).
- A starts a 2-byte frame, and B raises `valid` during A's first byte. Required: B's `ready` stays 0 until A's last byte completes, then B is granted.
- The transmitter model never raises busy, with `START_TO`=16. Required: `start_err` pulses exactly 17 cycles after `tx_load`, the frame continues, and the next byte loads.
- With `GAP_CYC`=4, two back-to-back bytes. Required: exactly 4 idle cycles between the busy fall and the next acceptance.
- Assert `rst` in WAIT_DONE. Required: the next cycle shows all outputs at their reset values and state IDLE, and a fresh A frame is served normally.
